// File: rtl/fetch_pkg.sv
// Shared types for the fetch path: queue entry layout, sequencer states, instruction size.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries.
// The head is read straight from the entry registers, so it is stable while not popped.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_wr_ptr;
    fetch_entry_t r_mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr[AW-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch buffer feeding decode. Optional macro FETCH_BOUNDS_CHECK_EN
// enables the out-of-bounds FAULT state and alignment assertions.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          IMEM_SIZE = 1024,
    parameter int          QDEPTH    = 2,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault
);
    localparam int CW = $clog2(QDEPTH) + 1;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
        IMEM_SIZE <= 4 || (IMEM_SIZE & (IMEM_SIZE - 1)) != 0) begin : g_bad_cfg
        $error("fetch_sequencer: QDEPTH and IMEM_SIZE must be powers of two in range");
    end

    fetch_state_e  r_state;
    fetch_state_e  w_state_next;
    logic [63:0]   r_pc;
    logic [63:0]   w_pc_next;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_oob;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;

    assign imem_addr   = r_pc;
    assign out_valid   = (w_count != '0);
    assign w_pop       = ~w_empty & out_ready;
    assign w_push_data = '{instr: imem_instr, pc: r_pc};
    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;

`ifdef FETCH_BOUNDS_CHECK_EN
    // pc > IMEM_SIZE-4 is pc+3 >= IMEM_SIZE without the carry-out hazard.
    assign w_oob       = (r_pc > 64'(IMEM_SIZE - INSTR_BYTES));
    assign fetch_fault = (r_state == FAULT);
`else
    assign w_oob       = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Redirect beats fetch; a pop in the same cycle still retires to decode.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        if (redirect_valid) begin
            w_state_next = RUN;
            w_pc_next    = {redirect_pc[63:2], 2'b00};
        end else if (r_state == RUN) begin
            if (w_oob) begin
                w_state_next = FAULT;
            end else if (~w_full | w_pop) begin
                w_push    = 1'b1;
                w_pc_next = r_pc + 64'(INSTR_BYTES);
            end
        end
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (w_push),
        .push_data(w_push_data),
        .pop      (w_pop),
        .head     (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    always @(posedge clk) begin
        if (!reset) begin
            assert (imem_addr[1:0] == 2'b00);
            if (redirect_valid) assert (redirect_pc[1:0] == 2'b00);
        end
    end
`endif

endmodule
